// File: rtl/screen_seq.sv
// Screen sequencer for the snake display path: title/play/game-over/restart flow
// plus the frame-buffer fill engine (address, x/y, write enable, source select).
module screen_seq #(
  parameter int H_PIX        = 160,
  parameter int V_PIX        = 120,
  parameter int ADDR_W       = 15,
  parameter int XW           = 8,
  parameter int YW           = 7,
  parameter int FLASH_TICKS  = 1,
  parameter int FLASH_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_is_dead,
  input  logic              i_tick,
  input  logic              i_pause,
  output logic              o_go,
  output logic              o_reset_ad,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [XW-1:0]     o_x_out,
  output logic [YW-1:0]     o_y_out,
  output logic [2:0]        o_screen_sel,
  output logic [3:0]        o_state
);

  // state      | meaning
  // DRAW_TITLE | fill frame with title image
  // TITLE      | wait for start key
  // DRAW_BLACK | clear frame before play
  // PLAY       | game logic running
  // PAUSED     | game logic frozen
  // DRAW_GO    | fill frame with game-over image
  // GO_WAIT    | show game-over for FLASH_TICKS ticks
  // DRAW_RED   | fill frame red
  // RED_WAIT   | show red for FLASH_TICKS ticks
  // RESTART    | hold game reset until start key released
  typedef enum logic [3:0] {
    S_DRAW_TITLE = 4'd0,
    S_TITLE      = 4'd1,
    S_DRAW_BLACK = 4'd2,
    S_PLAY       = 4'd3,
    S_PAUSED     = 4'd4,
    S_DRAW_GO    = 4'd5,
    S_GO_WAIT    = 4'd6,
    S_DRAW_RED   = 4'd7,
    S_RED_WAIT   = 4'd8,
    S_RESTART    = 4'd9
  } state_t;

  localparam int TCW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int FCW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

  localparam logic [XW-1:0]  X_LAST    = XW'(H_PIX - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(V_PIX - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(FLASH_TICKS - 1);
  localparam logic [FCW-1:0] FLASH_MAX = FCW'(FLASH_CYCLES);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [TCW-1:0]    r_tick_cnt;
  logic [FCW-1:0]    r_flash_cnt;

  logic   w_fill_last;
  logic   w_tick_last;
  logic   w_flash_done;
  state_t w_fill_next;

  assign w_fill_last  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_tick_last  = i_tick && (r_tick_cnt == TICK_LAST);
  assign w_flash_done = (FLASH_CYCLES != 0) && (r_flash_cnt == FLASH_MAX);

  always_comb begin
    w_fill_next = S_DRAW_TITLE;
    case (r_state)
      S_DRAW_TITLE: w_fill_next = S_TITLE;
      S_DRAW_BLACK: w_fill_next = S_PLAY;
      S_DRAW_GO:    w_fill_next = S_GO_WAIT;
      S_DRAW_RED:   w_fill_next = S_RED_WAIT;
      default:      w_fill_next = S_DRAW_TITLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_DRAW_TITLE;
      r_addr      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_tick_cnt  <= '0;
      r_flash_cnt <= '0;
    end else begin
      case (r_state)
        S_DRAW_TITLE, S_DRAW_BLACK, S_DRAW_GO, S_DRAW_RED: begin
          if (w_fill_last) begin
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= w_fill_next;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        S_TITLE: begin
          if (!i_start) r_state <= S_DRAW_BLACK;
        end
        S_PLAY: begin
          // death wins over pause so a dying snake can never be frozen
          if (i_is_dead) begin
            r_flash_cnt <= '0;
            r_state     <= S_DRAW_GO;
          end else if (i_pause) begin
            r_state <= S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (!i_pause) r_state <= S_PLAY;
        end
        S_GO_WAIT, S_RED_WAIT: begin
          if (!i_start) begin
            r_tick_cnt <= '0;
            r_state    <= S_RESTART;
          end else if (w_tick_last) begin
            r_tick_cnt <= '0;
            if (r_state == S_RED_WAIT) begin
              r_flash_cnt <= r_flash_cnt + FCW'(1);
              r_state     <= S_DRAW_GO;
            end else if (w_flash_done) begin
              r_state <= S_RESTART;
            end else begin
              r_state <= S_DRAW_RED;
            end
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
          end
        end
        S_RESTART: begin
          if (i_start) r_state <= S_DRAW_TITLE;
        end
        default: r_state <= S_DRAW_TITLE;
      endcase
    end
  end

  always_comb begin
    o_go         = 1'b0;
    o_reset_ad   = 1'b0;
    o_wren       = 1'b0;
    o_screen_sel = 3'd0;
    case (r_state)
      S_DRAW_TITLE: begin o_wren = 1'b1; o_screen_sel = 3'd1; end
      S_DRAW_BLACK: begin o_wren = 1'b1; o_screen_sel = 3'd2; end
      S_DRAW_GO:    begin o_wren = 1'b1; o_screen_sel = 3'd3; end
      S_DRAW_RED:   begin o_wren = 1'b1; o_screen_sel = 3'd4; end
      S_PLAY:       o_go = 1'b1;
      S_RESTART:    o_reset_ad = 1'b1;
      default:      o_go = 1'b0;
    endcase
  end

  assign o_wr_addr = r_addr;
  assign o_x_out   = r_x;
  assign o_y_out   = r_y;
  assign o_state   = r_state;

endmodule

// File: tb/tb_screen_seq.sv
// Scoreboard bench for screen_seq on a 4x3 frame with 2-tick flashes and 2 flash cycles.
module tb_screen_seq;

  localparam int H = 4;
  localparam int V = 3;
  localparam int AW = 15;
  localparam int XW = 8;
  localparam int YW = 7;

  typedef logic [39:0] vec_t;
  typedef struct {
    vec_t       exp;
    logic [3:0] stim;  // {start, is_dead, tick, pause} applied after the compare
  } step_t;

  localparam logic [3:0] IDLE = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n, start, is_dead, tick, pause;
  logic          go, reset_ad, wren;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    screen_sel;
  logic [3:0]    state;
  vec_t          obs;

  int n_checks = 0;
  int n_errors = 0;
  step_t q[$];

  screen_seq #(
    .H_PIX(H), .V_PIX(V), .ADDR_W(AW), .XW(XW), .YW(YW),
    .FLASH_TICKS(2), .FLASH_CYCLES(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_is_dead(is_dead),
    .i_tick(tick), .i_pause(pause), .o_go(go), .o_reset_ad(reset_ad),
    .o_wren(wren), .o_wr_addr(wr_addr), .o_x_out(x_out), .o_y_out(y_out),
    .o_screen_sel(screen_sel), .o_state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, wren, screen_sel, wr_addr, x_out, y_out, go, reset_ad};

  function automatic vec_t ev(int st, bit we, int sel, int addr, int x, int y, bit g, bit rad);
    return {4'(st), we, 3'(sel), 15'(addr), 8'(x), 7'(y), g, rad};
  endfunction

  task automatic push(vec_t e, logic [3:0] s);
    step_t t;
    t.exp  = e;
    t.stim = s;
    q.push_back(t);
  endtask

  task automatic push_fill(int st, int sel, int n);
    for (int p = 0; p < n; p++) push(ev(st, 1, sel, p, p % H, p / H, 0, 0), IDLE);
  endtask

  // Two-tick wait: a first tick must not end the phase, the second must.
  task automatic push_wait(int st);
    push(ev(st, 0, 0, 0, 0, 0, 0, 0), IDLE);
    push(ev(st, 0, 0, 0, 0, 0, 0, 0), 4'b1010);
    push(ev(st, 0, 0, 0, 0, 0, 0, 0), IDLE);
    push(ev(st, 0, 0, 0, 0, 0, 0, 0), 4'b1010);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; is_dead = 1'b0; tick = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs !== ev(0, 1, 1, 0, 0, 0, 0, 0)) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, ev(0, 1, 1, 0, 0, 0, 0, 0));
      end
      if (i == 0) @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_title_fill();
    int k = 0;
    push_fill(0, 1, H * V);
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL title_fill step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_start_black();
    int k = 0;
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), IDLE);
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), 4'b0000);
    push_fill(2, 2, H * V);
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL start_black step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_pause();
    int k = 0;
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), 4'b1001);
    push(ev(4, 0, 0, 0, 0, 0, 0, 0), 4'b1101);
    push(ev(4, 0, 0, 0, 0, 0, 0, 0), 4'b1001);
    push(ev(4, 0, 0, 0, 0, 0, 0, 0), IDLE);
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL pause step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_flash();
    int k = 0;
    // death and pause together: death must win
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), 4'b1101);
    for (int c = 0; c < 2; c++) begin
      push_fill(5, 3, H * V);
      push_wait(6);
      push_fill(7, 4, H * V);
      push_wait(8);
    end
    push_fill(5, 3, H * V);
    push_wait(6);
    push(ev(9, 0, 0, 0, 0, 0, 0, 1), IDLE);
    push_fill(0, 1, H * V);
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL flash step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_start_abort();
    int k = 0;
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), 4'b0000);
    push_fill(2, 2, H * V);
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), 4'b1100);
    push_fill(5, 3, H * V);
    push(ev(6, 0, 0, 0, 0, 0, 0, 0), IDLE);
    push(ev(6, 0, 0, 0, 0, 0, 0, 0), 4'b0010);
    for (int i = 0; i < 5; i++) push(ev(9, 0, 0, 0, 0, 0, 0, 1), 4'b0000);
    push(ev(9, 0, 0, 0, 0, 0, 0, 1), IDLE);
    push_fill(0, 1, H * V);
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL start_abort step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int k = 0;
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), 4'b0000);
    push_fill(2, 2, H * V);
    push(ev(3, 0, 0, 0, 0, 0, 1, 0), 4'b1100);
    push_fill(5, 3, H * V);
    push_wait(6);
    push_fill(7, 4, 5);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL reset_mid_fill step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (obs !== ev(7, 1, 4, 5, 1, 1, 0, 0)) begin
      n_errors++;
      $display("FAIL red_pixel5: got %h want %h", obs, ev(7, 1, 4, 5, 1, 1, 0, 0));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== ev(0, 1, 1, 0, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL async_reset: got %h want %h", obs, ev(0, 1, 1, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    push_fill(0, 1, H * V);
    push(ev(1, 0, 0, 0, 0, 0, 0, 0), IDLE);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      n_checks++;
      if (obs !== s.exp) begin
        n_errors++;
        $display("FAIL refill step %0d: got %h want %h", k, obs, s.exp);
      end
      {start, is_dead, tick, pause} = s.stim;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_title_fill();
    test_start_black();
    test_pause();
    test_flash();
    test_start_abort();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
